// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types for the memory line responder
package mem_resp_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_t;

    localparam int RESP_DATA_W   = 32;
    localparam int CD_W          = 8;
    localparam int DEF_NUM_WORDS = 256;

    typedef struct packed {
        mem_req_type_t          rtype;
        logic [RESP_DATA_W-1:0] data;
        logic                   err;
        logic [CD_W-1:0]        countdown;
    } resp_entry_t;

    function automatic int word_idx_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    localparam int WORD_IDX_W = word_idx_w(DEF_NUM_WORDS);

endpackage

// File: rtl/mem_resp_delay_queue.sv
// rtl/mem_resp_delay_queue.sv - in-order response queue with per-entry release countdown
module mem_resp_delay_queue
    import mem_resp_pkg::*;
#(
    parameter int Q_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_tvalid,
    input  resp_entry_t                  enq_tdata,
    input  logic                         deq_tready,
    output logic                         head_ready,
    output mem_req_type_t                head_type,
    output logic [RESP_DATA_W-1:0]       head_data,
    output logic                         head_err,
    output logic [$clog2(Q_DEPTH):0]     count
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    resp_entry_t      entries [Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             deq;

    assign head_ready = (count != '0) && (entries[rd_ptr].countdown == '0);
    assign head_type  = entries[rd_ptr].rtype;
    assign head_data  = entries[rd_ptr].data;
    assign head_err   = entries[rd_ptr].err;
    assign deq        = head_ready && deq_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // every slot counts down, including a stalled head
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (entries[i].countdown != '0) begin
                    entries[i].countdown <= entries[i].countdown - 1'b1;
                end
            end
            if (enq_tvalid) begin
                entries[wr_ptr] <= enq_tdata;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_tvalid, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - word-array memory behind the cache refill/evict port
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 4,
    parameter int Q_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cache_req_val,
    output logic                       cache_req_rdy,
    input  logic                       cache_req_type,
    input  logic [ADDR_W-1:0]          cache_req_addr,
    input  logic [DATA_W-1:0]          cache_req_data,
    output logic                       cache_resp_val,
    input  logic                       cache_resp_rdy,
    output logic                       cache_resp_type,
    output logic [DATA_W-1:0]          cache_resp_data,
    output logic                       cache_resp_err,
    output logic [$clog2(Q_DEPTH):0]   outstanding
);

    localparam int IDX_W = word_idx_w(NUM_WORDS);
    localparam int CNT_W = $clog2(Q_DEPTH) + 1;

    logic [DATA_W-1:0]      mem [NUM_WORDS];
    logic [ADDR_W-1:0]      word_addr;
    logic [IDX_W-1:0]       word_idx;
    logic                   in_range;
    logic                   accept;
    mem_req_type_t          req_type;
    resp_entry_t            enq_entry;
    logic                   head_ready;
    mem_req_type_t          head_type;
    logic [RESP_DATA_W-1:0] head_data;
    logic                   head_err;

    assign req_type  = mem_req_type_t'(cache_req_type);
    assign word_addr = cache_req_addr >> 2;
    assign word_idx  = word_addr[IDX_W-1:0];
    assign in_range  = word_addr < ADDR_W'(NUM_WORDS);

    assign cache_req_rdy = !reset && (outstanding < CNT_W'(Q_DEPTH));
    assign accept        = cache_req_val && cache_req_rdy;

    always_ff @(posedge clk) begin
        if (accept && in_range && req_type == MEM_WRITE) begin
            mem[word_idx] <= cache_req_data;
        end
    end

    // read data is taken from the array before this edge's write lands
    always_comb begin
        enq_entry           = '0;
        enq_entry.rtype     = req_type;
        enq_entry.err       = !in_range;
        enq_entry.countdown = CD_W'(LATENCY - 1);
        if (req_type == MEM_READ && in_range) begin
            enq_entry.data = RESP_DATA_W'(mem[word_idx]);
        end
    end

    mem_resp_delay_queue #(
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .enq_tvalid (accept),
        .enq_tdata  (enq_entry),
        .deq_tready (cache_resp_rdy),
        .head_ready (head_ready),
        .head_type  (head_type),
        .head_data  (head_data),
        .head_err   (head_err),
        .count      (outstanding)
    );

    assign cache_resp_val  = head_ready;
    assign cache_resp_type = head_ready && (head_type == MEM_WRITE);
    assign cache_resp_data = head_ready ? DATA_W'(head_data) : '0;
    assign cache_resp_err  = head_ready && head_err;

endmodule
